// File: rtl/uart_rx.sv
// 8N1 UART receiver for the Z80 console port.
// Deserialises RXD into an 8-byte FWFT FIFO with sticky framing/overrun flags.
module uart_rx #(
    parameter int CLKS_PER_BIT = 1302,
    parameter int FIFO_AW      = 3
) (
    input  logic       CLK50M,
    input  logic       RST,
    input  logic       RXD,
    input  logic       RD_STB,
    input  logic       ERR_CLR,
    output logic [7:0] RX_DATA,
    output logic       RX_VALID,
    output logic       FRAME_ERR,
    output logic       OVERRUN
);

    localparam int HALF  = CLKS_PER_BIT / 2;
    localparam int CW    = $clog2(CLKS_PER_BIT);
    localparam int DEPTH = 2 ** FIFO_AW;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BRK
    } state_t;

    state_t           state;
    logic             sync1;
    logic             sync2;
    logic             prev;
    logic [CW-1:0]    cnt;
    logic [2:0]       idx;
    logic [7:0]       shreg;
    logic [7:0]       mem [DEPTH];
    logic [FIFO_AW:0] wr_ptr;
    logic [FIFO_AW:0] rd_ptr;

    logic expire;
    logic stop_hit;
    logic push_req;
    logic fe_set;
    logic ovr_set;
    logic full;
    logic empty;
    logic pop_en;
    logic push_en;

    assign expire   = (cnt == '0);
    assign stop_hit = (state == STOP) && expire;
    assign push_req = stop_hit && sync2;
    assign fe_set   = stop_hit && !sync2;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]) &&
                   (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]);

    // A pop frees a slot in the same cycle, so a full FIFO can still accept
    assign pop_en  = RD_STB && !empty;
    assign push_en = push_req && (!full || pop_en);
    assign ovr_set = push_req && full && !pop_en;

    assign RX_VALID = !empty;
    assign RX_DATA  = mem[rd_ptr[FIFO_AW-1:0]];

    always_ff @(posedge CLK50M or posedge RST) begin
        if (RST) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            prev  <= 1'b0;
        end else begin
            sync1 <= RXD;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    always_ff @(posedge CLK50M or posedge RST) begin
        if (RST) begin
            state <= IDLE;
            cnt   <= '0;
            idx   <= '0;
            shreg <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (!sync2 && prev) begin
                        cnt   <= CW'(HALF - 1);
                        state <= START;
                    end
                end
                START: begin
                    if (!expire) begin
                        cnt <= cnt - CW'(1);
                    end else if (!sync2) begin
                        cnt   <= CW'(CLKS_PER_BIT - 1);
                        idx   <= '0;
                        state <= DATA;
                    end else begin
                        state <= IDLE;
                    end
                end
                DATA: begin
                    if (!expire) begin
                        cnt <= cnt - CW'(1);
                    end else begin
                        shreg <= {sync2, shreg[7:1]};
                        cnt   <= CW'(CLKS_PER_BIT - 1);
                        idx   <= idx + 3'd1;
                        if (idx == 3'd7) begin
                            state <= STOP;
                        end
                    end
                end
                STOP: begin
                    if (!expire) begin
                        cnt <= cnt - CW'(1);
                    end else begin
                        state <= sync2 ? IDLE : BRK;
                    end
                end
                BRK: begin
                    if (sync2) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK50M or posedge RST) begin
        if (RST) begin
            FRAME_ERR <= 1'b0;
            OVERRUN   <= 1'b0;
        end else begin
            FRAME_ERR <= fe_set  || (FRAME_ERR && !ERR_CLR);
            OVERRUN   <= ovr_set || (OVERRUN && !ERR_CLR);
        end
    end

    always_ff @(posedge CLK50M or posedge RST) begin
        if (RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push_en) begin
                mem[wr_ptr[FIFO_AW-1:0]] <= shreg;
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_en) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Randomised bench for uart_rx against a queue-based FIFO/flag model.
// A 1302-clock instance covers the nominal timing case; a 16-clock one the rest.
module tb_uart_rx;

    localparam int CPB  = 16;
    localparam int HALF = CPB / 2;
    localparam int SS   = 2 + HALF + 9 * CPB;
    localparam int LAT  = SS + 1;
    localparam int SCPB = 1302;
    localparam int SLAT = 3 + SCPB / 2 + 9 * SCPB;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rxd_s = 1'b1;
    logic       rxd_f = 1'b1;
    logic       rd_stb = 1'b0;
    logic       err_clr = 1'b0;
    logic [7:0] data_s, data_f;
    logic       valid_s, valid_f;
    logic       fe_s, fe_f;
    logic       ov_s, ov_f;

    int         vectors = 0;
    int         errs = 0;
    int         cyc = 0;
    int         rise_s = 0;
    int         rise_f = 0;
    logic       pv_s = 1'b0;
    logic       pv_f = 1'b0;

    logic [7:0] q[$];
    logic       m_fe = 1'b0;
    logic       m_ov = 1'b0;

    always #5 clk = ~clk;

    uart_rx #(.CLKS_PER_BIT(SCPB), .FIFO_AW(3)) dut_s (
        .CLK50M(clk), .RST(rst), .RXD(rxd_s), .RD_STB(rd_stb),
        .ERR_CLR(err_clr), .RX_DATA(data_s), .RX_VALID(valid_s),
        .FRAME_ERR(fe_s), .OVERRUN(ov_s)
    );

    uart_rx #(.CLKS_PER_BIT(CPB), .FIFO_AW(3)) dut_f (
        .CLK50M(clk), .RST(rst), .RXD(rxd_f), .RD_STB(rd_stb),
        .ERR_CLR(err_clr), .RX_DATA(data_f), .RX_VALID(valid_f),
        .FRAME_ERR(fe_f), .OVERRUN(ov_f)
    );

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        pv_s <= valid_s;
        pv_f <= valid_f;
        if (valid_s && !pv_s) rise_s <= cyc;
        if (valid_f && !pv_f) rise_f <= cyc;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic frame(input logic [7:0] b, input bit slow,
                         input int stop_low, input int rd_at,
                         input int clr_at, output int ts);
        int   cpb = slow ? SCPB : CPB;
        int   nb  = 9 + ((stop_low > 0) ? stop_low : 1);
        logic v;
        ts = cyc;
        for (int c = 0; c < nb * cpb; c++) begin
            int bi = c / cpb;
            if (bi == 0) v = 1'b0;
            else if (bi <= 8) v = b[bi-1];
            else v = (stop_low == 0);
            if (slow) rxd_s = v;
            else rxd_f = v;
            rd_stb  = (c == rd_at);
            err_clr = (c == clr_at);
            @(posedge clk);
            #1;
        end
        rd_stb  = 1'b0;
        err_clr = 1'b0;
        if (slow) rxd_s = 1'b1;
        else rxd_f = 1'b1;
    endtask

    // Events inside one frame, applied in cycle order; a clear on the
    // stop-sample cycle loses to a flag raised in that same cycle.
    task automatic model(input logic [7:0] b, input int stop_low,
                         input int rd_at, input int clr_at);
        if (rd_at >= 0 && rd_at <= SS && q.size() > 0) q.delete(0);
        if (clr_at >= 0 && clr_at <= SS) begin
            m_fe = 1'b0;
            m_ov = 1'b0;
        end
        if (stop_low == 0) begin
            if (q.size() < 8) q.push_back(b);
            else m_ov = 1'b1;
        end else begin
            m_fe = 1'b1;
        end
        if (rd_at > SS && q.size() > 0) q.delete(0);
        if (clr_at > SS) begin
            m_fe = 1'b0;
            m_ov = 1'b0;
        end
    endtask

    task automatic send_f(input logic [7:0] b, input int stop_low,
                          input int rd_at, input int clr_at,
                          output int ts);
        frame(b, 1'b0, stop_low, rd_at, clr_at, ts);
        model(b, stop_low, rd_at, clr_at);
    endtask

    task automatic pop();
        rd_stb = 1'b1;
        step(1);
        rd_stb = 1'b0;
        if (q.size() > 0) q.delete(0);
    endtask

    task automatic clear_flags();
        err_clr = 1'b1;
        step(1);
        err_clr = 1'b0;
        m_fe = 1'b0;
        m_ov = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(3);
        vectors++; if (valid_f !== 1'b0) begin errs++; $display("FAIL rst_valid_f: got %b want 0", valid_f); end
        vectors++; if (data_f !== 8'h00) begin errs++; $display("FAIL rst_data_f: got %h want 00", data_f); end
        vectors++; if (fe_f !== 1'b0) begin errs++; $display("FAIL rst_fe_f: got %b want 0", fe_f); end
        vectors++; if (ov_f !== 1'b0) begin errs++; $display("FAIL rst_ov_f: got %b want 0", ov_f); end
        vectors++; if (valid_s !== 1'b0) begin errs++; $display("FAIL rst_valid_s: got %b want 0", valid_s); end
        vectors++; if (data_s !== 8'h00) begin errs++; $display("FAIL rst_data_s: got %h want 00", data_s); end
        rst = 1'b0;
        step(5);
        vectors++; if (valid_f !== 1'b0) begin errs++; $display("FAIL idle_valid: got %b want 0", valid_f); end
        vectors++; if (fe_f !== 1'b0) begin errs++; $display("FAIL idle_fe: got %b want 0", fe_f); end
    endtask

    task automatic test_nominal();
        int         ts;
        logic [7:0] b;
        frame(8'h41, 1'b1, 0, -1, -1, ts);
        step(2);
        vectors++; if (rise_s - ts !== SLAT) begin errs++; $display("FAIL nom_latency: got %0d want %0d", rise_s - ts, SLAT); end
        vectors++; if (valid_s !== 1'b1) begin errs++; $display("FAIL nom_valid: got %b want 1", valid_s); end
        vectors++; if (data_s !== 8'h41) begin errs++; $display("FAIL nom_data: got %h want 41", data_s); end
        vectors++; if ({fe_s, ov_s} !== 2'b00) begin errs++; $display("FAIL nom_flags: got %b want 00", {fe_s, ov_s}); end
        rd_stb = 1'b1;
        step(1);
        rd_stb = 1'b0;
        vectors++; if (valid_s !== 1'b0) begin errs++; $display("FAIL nom_pop: got %b want 0", valid_s); end
        b = 8'($urandom);
        send_f(b, 0, -1, -1, ts);
        step(2);
        vectors++; if (rise_f - ts !== LAT) begin errs++; $display("FAIL fast_latency: got %0d want %0d", rise_f - ts, LAT); end
        vectors++; if (data_f !== q[0]) begin errs++; $display("FAIL fast_data: got %h want %h", data_f, q[0]); end
        pop();
        vectors++; if (valid_f !== 1'b0) begin errs++; $display("FAIL fast_pop: got %b want 0", valid_f); end
    endtask

    task automatic test_glitch();
        int         ts;
        logic [7:0] b;
        rxd_f = 1'b0;
        step(5);
        rxd_f = 1'b1;
        step(3 * CPB);
        vectors++; if (valid_f !== 1'b0) begin errs++; $display("FAIL glitch_valid: got %b want 0", valid_f); end
        vectors++; if ({fe_f, ov_f} !== 2'b00) begin errs++; $display("FAIL glitch_flags: got %b want 00", {fe_f, ov_f}); end
        b = 8'($urandom);
        send_f(b, 0, -1, -1, ts);
        step(2);
        vectors++; if (rise_f - ts !== LAT) begin errs++; $display("FAIL glitch_after_lat: got %0d want %0d", rise_f - ts, LAT); end
        vectors++; if (data_f !== q[0]) begin errs++; $display("FAIL glitch_after_data: got %h want %h", data_f, q[0]); end
        pop();
    endtask

    task automatic test_framing();
        int ts;
        send_f(8'h55, 3, -1, -1, ts);
        step(2 * CPB);
        vectors++; if (fe_f !== m_fe) begin errs++; $display("FAIL fe_set: got %b want %b", fe_f, m_fe); end
        vectors++; if (valid_f !== (q.size() > 0)) begin errs++; $display("FAIL fe_fifo: got %b want %b", valid_f, q.size() > 0); end
        vectors++; if (ov_f !== m_ov) begin errs++; $display("FAIL fe_ov: got %b want %b", ov_f, m_ov); end
        clear_flags();
        vectors++; if (fe_f !== m_fe) begin errs++; $display("FAIL fe_clear: got %b want %b", fe_f, m_fe); end
        send_f(8'($urandom), 3, -1, SS + 3, ts);
        step(2 * CPB);
        vectors++; if (fe_f !== m_fe) begin errs++; $display("FAIL break_once: got %b want %b", fe_f, m_fe); end
        send_f(8'h3C, 0, -1, -1, ts);
        step(2);
        vectors++; if (valid_f !== 1'b1 || data_f !== 8'h3C) begin errs++; $display("FAIL fe_next: got %b/%h want 1/3c", valid_f, data_f); end
        vectors++; if (fe_f !== m_fe) begin errs++; $display("FAIL fe_next_flag: got %b want %b", fe_f, m_fe); end
        pop();
        vectors++; if (valid_f !== 1'b0) begin errs++; $display("FAIL fe_pop: got %b want 0", valid_f); end
    endtask

    task automatic test_overrun();
        int ts;
        for (int i = 1; i <= 9; i++) begin
            send_f(8'(i), 0, -1, (i == 9) ? SS : -1, ts);
        end
        step(2);
        vectors++; if (ov_f !== m_ov) begin errs++; $display("FAIL ov_set: got %b want %b", ov_f, m_ov); end
        vectors++; if (fe_f !== m_fe) begin errs++; $display("FAIL ov_fe: got %b want %b", fe_f, m_fe); end
        for (int i = 0; i < 8; i++) begin
            vectors++; if (valid_f !== 1'b1 || data_f !== q[0]) begin errs++; $display("FAIL ov_read%0d: got %b/%h want 1/%h", i, valid_f, data_f, q[0]); end
            pop();
        end
        vectors++; if (valid_f !== 1'b0) begin errs++; $display("FAIL ov_empty: got %b want 0", valid_f); end
        clear_flags();
        vectors++; if (ov_f !== 1'b0) begin errs++; $display("FAIL ov_clear: got %b want 0", ov_f); end
    endtask

    task automatic test_simul();
        int ts;
        for (int i = 0; i < 8; i++) send_f(8'($urandom), 0, -1, -1, ts);
        step(2);
        vectors++; if (ov_f !== m_ov) begin errs++; $display("FAIL full_ov: got %b want %b", ov_f, m_ov); end
        send_f(8'($urandom), 0, SS, -1, ts);
        step(2);
        vectors++; if (ov_f !== m_ov) begin errs++; $display("FAIL simul_ov: got %b want %b", ov_f, m_ov); end
        for (int i = 0; i < 8; i++) begin
            vectors++; if (valid_f !== 1'b1 || data_f !== q[0]) begin errs++; $display("FAIL simul_read%0d: got %b/%h want 1/%h", i, valid_f, data_f, q[0]); end
            pop();
        end
        vectors++; if (valid_f !== 1'b0) begin errs++; $display("FAIL simul_count: got %b want 0", valid_f); end
    endtask

    task automatic test_back_to_back();
        int ts;
        int rd;
        for (int i = 0; i < 20; i++) begin
            vectors++; if (valid_f !== (q.size() > 0)) begin errs++; $display("FAIL b2b_valid%0d: got %b want %b", i, valid_f, q.size() > 0); end
            if (q.size() > 0) begin
                vectors++; if (data_f !== q[0]) begin errs++; $display("FAIL b2b_head%0d: got %h want %h", i, data_f, q[0]); end
            end
            rd = ($urandom_range(0, 2) == 0) ? -1 : int'($urandom_range(0, 10 * CPB - 1));
            send_f(8'($urandom), 0, rd, -1, ts);
        end
        for (int i = 0; i < 8 && q.size() > 0; i++) begin
            vectors++; if (data_f !== q[0]) begin errs++; $display("FAIL b2b_drain%0d: got %h want %h", i, data_f, q[0]); end
            pop();
        end
        vectors++; if ({valid_f, ov_f} !== {1'b0, m_ov}) begin errs++; $display("FAIL b2b_end: got %b want %b", {valid_f, ov_f}, {1'b0, m_ov}); end
        clear_flags();
    endtask

    task automatic test_reset_mid();
        int         ts;
        logic [7:0] b;
        send_f(8'h12, 0, -1, -1, ts);
        send_f(8'($urandom), 1, -1, -1, ts);
        step(2 * CPB);
        vectors++; if ({valid_f, fe_f} !== 2'b11) begin errs++; $display("FAIL pre_rst: got %b want 11", {valid_f, fe_f}); end
        b = 8'($urandom);
        rxd_f = 1'b0;
        step(CPB);
        for (int k = 0; k < 3; k++) begin
            rxd_f = b[k];
            step(CPB);
        end
        rxd_f = b[3];
        step(CPB / 2);
        rst = 1'b1;
        rxd_f = 1'b1;
        #1;
        vectors++; if ({valid_f, fe_f, ov_f} !== 3'b000) begin errs++; $display("FAIL mid_rst_flags: got %b want 000", {valid_f, fe_f, ov_f}); end
        vectors++; if (data_f !== 8'h00) begin errs++; $display("FAIL mid_rst_data: got %h want 00", data_f); end
        step(3);
        rst = 1'b0;
        q.delete();
        m_fe = 1'b0;
        m_ov = 1'b0;
        step(3 * CPB);
        send_f(8'hA5, 0, -1, -1, ts);
        step(2);
        vectors++; if (rise_f - ts !== LAT) begin errs++; $display("FAIL post_rst_lat: got %0d want %0d", rise_f - ts, LAT); end
        vectors++; if (valid_f !== 1'b1 || data_f !== 8'hA5) begin errs++; $display("FAIL post_rst_data: got %b/%h want 1/a5", valid_f, data_f); end
        vectors++; if ({fe_f, ov_f} !== 2'b00) begin errs++; $display("FAIL post_rst_flags: got %b want 00", {fe_f, ov_f}); end
        pop();
        vectors++; if (valid_f !== 1'b0) begin errs++; $display("FAIL post_rst_pop: got %b want 0", valid_f); end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_glitch();
        test_framing();
        test_overrun();
        test_simul();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
